// File: rtl/neuron_seq.sv
`timescale 1ns/1ps
// Serial MAC neuron: N_INPUTS (a,w) beats accumulate, then bias, saturate and activate.
// Result appears one cycle after the last beat; input stalls while a result waits on out_ready.

// Piecewise-linear tanh in Q(WIDTH-FBITS).FBITS, odd-symmetric, shift-add slopes only.
module tanh_q #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24
) (
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);
  localparam int AW = WIDTH + 1;
  localparam logic [AW-1:0] ONE     = AW'(1) << FBITS;
  localparam logic [AW-1:0] HALF    = ONE >> 1;
  localparam logic [AW-1:0] ONE_H   = (AW'(3) << FBITS) >> 1;
  localparam logic [AW-1:0] TWO     = AW'(2) << FBITS;
  localparam logic [AW-1:0] THREE   = AW'(3) << FBITS;
  // Segment offsets in 1/256ths of one, chosen so each chord hugs the curve.
  localparam logic [AW-1:0] C1 = (AW'(38) << FBITS) >> 8;
  localparam logic [AW-1:0] C2 = (AW'(134) << FBITS) >> 8;
  localparam logic [AW-1:0] C3 = (AW'(184) << FBITS) >> 8;
  localparam logic [AW-1:0] C4 = (AW'(230) << FBITS) >> 8;

  logic [AW-1:0] xe, ax, r;

  always_comb begin
    xe = {x[WIDTH-1], x};
    ax = x[WIDTH-1] ? (~xe + AW'(1)) : xe;
    if (ax < HALF)       r = ax - (ax >> 4);
    else if (ax < ONE)   r = (ax >> 1) + (ax >> 3) + C1;
    else if (ax < ONE_H) r = (ax >> 2) + C2;
    else if (ax < TWO)   r = (ax >> 3) + C3;
    else if (ax < THREE) r = (ax >> 5) + C4;
    else                 r = ONE;
    y = x[WIDTH-1] ? WIDTH'(~r + AW'(1)) : WIDTH'(r);
  end
endmodule

module neuron_seq #(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 24,
  parameter int N_INPUTS = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_w,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y,
  output logic                    busy
);
  localparam int ACC_W = WIDTH + $clog2(N_INPUTS) + 1;
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, ACT, OUT} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc, prod_ext, sum;
  logic signed [WIDTH-1:0] bias_r, sat, tanh_y, act_y;
  logic [1:0]              mode_r;
  logic [2*WIDTH-1:0]      prod_full;
  logic                    accept;
  logic                    unused_prod;

  // Low 2W bits of the sign-extended product equal the signed product; taking
  // bits [FBITS +: WIDTH] is the floor shift followed by the wrapping truncation.
  always_comb begin
    prod_full = {{WIDTH{in_a[WIDTH-1]}}, in_a} * {{WIDTH{in_w[WIDTH-1]}}, in_w};
    prod_ext  = {{(ACC_W-WIDTH){prod_full[FBITS+WIDTH-1]}}, prod_full[FBITS +: WIDTH]};
  end
  assign unused_prod = ^{prod_full[FBITS-1:0], prod_full[2*WIDTH-1:FBITS+WIDTH]};

  always_comb begin
    sum = acc + {{(ACC_W-WIDTH){bias_r[WIDTH-1]}}, bias_r};
    if (sum > SMAX)      sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (sum < SMIN) sat = {1'b1, {(WIDTH-1){1'b0}}};
    else                 sat = sum[WIDTH-1:0];
  end

  tanh_q #(.WIDTH(WIDTH), .FBITS(FBITS)) u_tanh (.x(sat), .y(tanh_y));

  always_comb begin
    unique case (mode_r)
      2'b00:   act_y = tanh_y;
      2'b01:   act_y = sat[WIDTH-1] ? '0 : sat;
      default: act_y = sat;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || (state == ACC);
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    if (accept) state_nxt = (N_INPUTS == 1) ? ACT : ACC;
      ACC:     if (accept && cnt == LAST) state_nxt = ACT;
      ACT:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      bias_r    <= '0;
      mode_r    <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          acc    <= prod_ext;
          bias_r <= in_b;
          mode_r <= mode;
          cnt    <= CNT_W'(1);
        end
        ACC: if (accept) begin
          acc <= acc + prod_ext;
          cnt <= cnt + CNT_W'(1);
        end
        ACT: begin
          y         <= act_y;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_seq.sv
`timescale 1ns/1ps
// Randomized bench for neuron_seq: a driver issues neurons and queues expected results,
// a negedge monitor compares every presented result and the one-cycle latency.
module tb_neuron_seq;
  localparam int N = 9;
  localparam real SCALE = 16777216.0;
  localparam real TOL = 419430.0;  // 0.025 in Q8.24

  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [1:0] mode = 2'b00;
  logic signed [31:0] in_a = 0, in_w = 0, in_b = 0, y;

  neuron_seq #(.WIDTH(32), .FBITS(24), .N_INPUTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_w(in_w), .in_b(in_b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_tanh; int val;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int beats = 0, wait_out = 0;
  bit rand_rdy = 1'b0;
  real ev, dv;

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  // Reference: exact products with floor shift, wrapped to 32 bits, summed wide.
  function automatic exp_t model(int a[N], int w[N], int b, logic [1:0] m);
    exp_t e;
    longint s, p;
    int sat;
    s = longint'(b);
    for (int i = 0; i < N; i++) begin
      p = (longint'(a[i]) * longint'(w[i])) >>> 24;
      s += longint'(int'(p));
    end
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    sat = int'(s);
    e.is_tanh = (m == 2'b00);
    e.val = (m == 2'b01 && sat < 0) ? 0 : sat;
    return e;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats = 0;
      wait_out = 0;
    end else begin
      if (wait_out > 0) begin
        wait_out--;
        if (wait_out == 1) chk("act_cycle_out_valid", out_valid, 0);
        else chk("latency_out_valid", out_valid, 1);
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got y %0h, required no result", y);
        end else begin
          mon_e = sbq[0];
          if (mon_e.is_tanh) begin
            ev = $tanh(real'(mon_e.val) / SCALE) * SCALE;
            dv = real'(y) - ev;
            checks++;
            if (dv > TOL || dv < -TOL) begin
              errors++;
              $display("FAIL tanh_y: got %0h required about %0f (sat %0h)", y, ev, mon_e.val);
            end
          end else chk("y", y, mon_e.val);
          chk("in_ready_while_out", in_ready, 0);
          if (out_ready) void'(sbq.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        beats++;
        if (beats == N) begin beats = 0; wait_out = 2; end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int a[N], input int w[N], input int b, input logic [1:0] m,
                      input bit bubbles, input int nb, input bit exact, input int yexp);
    exp_t e;
    bit took;
    int guard;
    for (int i = 0; i < nb; i++) begin
      if (bubbles && i > 0) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1; in_a = a[i]; in_w = w[i];
      in_b = (i == 0) ? b : int'($urandom);
      mode = (i == 0) ? m : 2'($urandom);
      took = 1'b0; guard = 0;
      while (!took && guard < 300) begin
        @(negedge clk); took = in_ready; tick(); guard++;
      end
      if (!took) begin
        checks++; errors++;
        $display("FAIL accept_timeout: beat %0d got no in_ready, required accept", i);
      end
    end
    in_valid = 1'b0; in_a = int'($urandom); in_w = int'($urandom);
    if (nb == N) begin
      if (exact) begin e.is_tanh = 1'b0; e.val = yexp; end
      else e = model(a, w, b, m);
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((sbq.size() != 0 || busy) && guard < 500) begin tick(); guard++; end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sbq.size());
    end
  endtask

  function automatic int rnd_val(int sel);
    if (sel == 0) return int'($urandom_range(0, 32'h04000000)) - 32'sh02000000;
    if (sel == 1) return int'($urandom_range(0, 32'h7FFFFFFF)) >>> 4;
    return int'($urandom);
  endfunction

  initial begin
    int a[N], w[N];
    int guard;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_y", y, 0);
    chk("reset_busy", busy, 0);
    #9 rst_n = 1'b1;
    #1 chk("reset_in_ready", in_ready, 1);
    tick();

    foreach (a[i]) begin a[i] = 32'h01000000; w[i] = 32'h00800000; end
    send(a, w, 0, 2'b10, 1'b0, N, 1'b1, 32'h04800000); drain();

    foreach (a[i]) begin a[i] = 32'h64000000; w[i] = 32'h01000000; end
    send(a, w, 0, 2'b10, 1'b0, N, 1'b1, 32'h7FFFFFFF); drain();
    foreach (a[i]) a[i] = 32'h9C000000;
    send(a, w, 0, 2'b10, 1'b0, N, 1'b1, 32'h80000000); drain();

    foreach (a[i]) a[i] = 0;
    a[0] = 32'hFF000000;
    send(a, w, 32'h00400000, 2'b01, 1'b0, N, 1'b1, 0); drain();
    send(a, w, 32'h02000000, 2'b01, 1'b0, N, 1'b1, 32'h01000000); drain();

    foreach (a[i]) begin a[i] = 0; w[i] = 0; end
    send(a, w, 0, 2'b00, 1'b0, N, 1'b1, 0); drain();
    send(a, w, 32'h7F000000, 2'b00, 1'b0, N, 1'b0, 0); drain();

    // Bubbled input, then a held result under backpressure.
    foreach (a[i]) begin a[i] = 32'h01000000; w[i] = 32'h00800000; end
    out_ready = 1'b0;
    send(a, w, 0, 2'b10, 1'b1, N, 1'b1, 32'h04800000);
    guard = 0;
    while (!out_valid && guard < 20) begin tick(); guard++; end
    for (int k = 0; k < 5; k++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("post_handshake_in_ready", in_ready, 1);
    chk("post_handshake_out_valid", out_valid, 0);
    drain();

    // Asynchronous reset after 4 beats drops the partial sum.
    send(a, w, 0, 2'b10, 1'b0, 4, 1'b0, 0);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #0.5;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_in_ready", in_ready, 1);
    tick();
    send(a, w, 0, 2'b10, 1'b0, N, 1'b1, 32'h04800000); drain();

    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int sel, b;
      sel = $urandom_range(0, 2);
      foreach (a[i]) begin a[i] = rnd_val(sel); w[i] = rnd_val(sel); end
      b = rnd_val($urandom_range(0, 2));
      send(a, w, b, 2'($urandom), 1'($urandom_range(0, 1)), N, 1'b0, 0);
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end
endmodule
